// File: rtl/span_scheduler.sv
// Frame/scanline sequencer for a bank of triangle interpolators; forwards captured spans downstream.
// Optional SPAN_SCHED_STATS_EN adds saturating span and stall counters.
module span_scheduler #(
  parameter int          NUM_TRI = 4,
  parameter logic [7:0]  Y_LAST  = 8'd239
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  input  logic                   start_i,
  input  logic [NUM_TRI-1:0]     tri_en_i,
  output logic [7:0]             y_o,
  output logic [NUM_TRI-1:0]     step_o,
  input  logic [8*NUM_TRI-1:0]   x_start_i,
  input  logic [8*NUM_TRI-1:0]   x_end_i,
  input  logic [NUM_TRI-1:0]     span_ok_i,
  output logic                   span_valid_o,
  input  logic                   span_ready_i,
  output logic [7:0]             span_y_o,
  output logic [7:0]             span_x0_o,
  output logic [7:0]             span_x1_o,
  output logic [2:0]             span_id_o,
  output logic                   busy_o,
  output logic                   frame_done_o,
`ifdef SPAN_SCHED_STATS_EN
  output logic [15:0]            span_cnt_o,
  output logic [15:0]            stall_cnt_o,
`endif
  output logic [2:0]             state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STEP  = 3'd1,
    CAPT  = 3'd2,
    EMIT  = 3'd3,
    NEXTL = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t               state;
  logic [NUM_TRI-1:0]   en_mask;
  logic [2:0]           idx;
  logic [7:0]           x0_q;
  logic [7:0]           x1_q;

  function automatic logic [2:0] lowest(input logic [NUM_TRI-1:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = NUM_TRI - 1; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [NUM_TRI-1:0] onehot(input logic [2:0] k);
    logic [NUM_TRI-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_TRI; i++) begin
      if (3'(i) == k) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Priority search for the next enabled unit strictly above idx.
  logic       nxt_any;
  logic [2:0] nxt_idx;
  always_comb begin
    nxt_any = 1'b0;
    nxt_idx = 3'd0;
    for (int i = NUM_TRI - 1; i >= 0; i--) begin
      if (en_mask[i] && (3'(i) > idx)) begin
        nxt_any = 1'b1;
        nxt_idx = 3'(i);
      end
    end
  end

  logic [7:0] cur_xs;
  logic [7:0] cur_xe;
  logic       cur_ok;
  always_comb begin
    cur_xs = 8'd0;
    cur_xe = 8'd0;
    cur_ok = 1'b0;
    for (int i = 0; i < NUM_TRI; i++) begin
      if (3'(i) == idx) begin
        cur_xs = x_start_i[8*i +: 8];
        cur_xe = x_end_i[8*i +: 8];
        cur_ok = span_ok_i[i];
      end
    end
  end

  // Handshake: span_valid_o is held with stable fields until the cycle in which
  // span_ready_i is also high; that cycle is the single transfer.
  logic handshake;
  assign handshake = (state == EMIT) && span_ready_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state        <= IDLE;
      en_mask      <= '0;
      idx          <= 3'd0;
      y_o          <= 8'd0;
      step_o       <= '0;
      x0_q         <= 8'd0;
      x1_q         <= 8'd0;
      span_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            en_mask <= tri_en_i;
            y_o     <= 8'd0;
            if (tri_en_i == '0) begin
              state        <= DONE;
              frame_done_o <= 1'b1;
              busy_o       <= 1'b0;
            end else begin
              idx    <= lowest(tri_en_i);
              step_o <= onehot(lowest(tri_en_i));
              busy_o <= 1'b1;
              state  <= STEP;
            end
          end
        end
        STEP: begin
          step_o <= '0;
          state  <= CAPT;
        end
        CAPT: begin
          // Unit outputs are registered, so they are valid one cycle after the strobe.
          x0_q <= (cur_xs < cur_xe) ? cur_xs : cur_xe;
          x1_q <= (cur_xs < cur_xe) ? cur_xe : cur_xs;
          if (cur_ok) begin
            span_valid_o <= 1'b1;
            state        <= EMIT;
          end else if (nxt_any) begin
            idx    <= nxt_idx;
            step_o <= onehot(nxt_idx);
            state  <= STEP;
          end else begin
            state <= NEXTL;
          end
        end
        EMIT: begin
          if (handshake) begin
            span_valid_o <= 1'b0;
            if (nxt_any) begin
              idx    <= nxt_idx;
              step_o <= onehot(nxt_idx);
              state  <= STEP;
            end else begin
              state <= NEXTL;
            end
          end
        end
        NEXTL: begin
          if (y_o == Y_LAST) begin
            state        <= DONE;
            frame_done_o <= 1'b1;
            busy_o       <= 1'b0;
          end else begin
            y_o    <= y_o + 8'd1;
            idx    <= lowest(en_mask);
            step_o <= onehot(lowest(en_mask));
            state  <= STEP;
          end
        end
        DONE: begin
          frame_done_o <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state        <= IDLE;
          step_o       <= '0;
          span_valid_o <= 1'b0;
          busy_o       <= 1'b0;
          frame_done_o <= 1'b0;
        end
      endcase
    end
  end

  assign span_y_o  = y_o;
  assign span_id_o = idx;
  assign span_x0_o = x0_q;
  assign span_x1_o = x1_q;
  assign state_o   = state;

`ifdef SPAN_SCHED_STATS_EN
  logic [15:0] span_cnt_q;
  logic [15:0] stall_cnt_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      span_cnt_q  <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else if ((state == IDLE) && start_i) begin
      span_cnt_q  <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else if (state == EMIT) begin
      if (span_ready_i && (span_cnt_q != 16'hFFFF)) span_cnt_q <= span_cnt_q + 16'd1;
      if (!span_ready_i && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign span_cnt_o  = span_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
